// File: rtl/completion_writer.sv
// Completion writer: FIFOs scheduler {pid,jobid} records, issues one host write each.
// Ports: clk/rst_n, complete_push_i/return_data_i/complete_ready_o in, wr_* out, counters.
module completion_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SLOT_SHIFT = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          complete_push_i,
  input  logic [40:0]                   return_data_i,
  output logic                          complete_ready_o,
  input  logic                          cmpl_enable_i,
  input  logic [63:0]                   cmpl_base_addr_i,
  output logic                          wr_req_o,
  output logic [63:0]                   wr_addr_o,
  output logic [127:0]                  wr_data_o,
  input  logic                          wr_ack_i,
  output logic [31:0]                   done_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state_q, state_d;

  logic [40:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] level;
  logic [PW-1:0] level_nxt;
  logic          ready_q;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ack;
  logic [40:0]   head;
  logic [31:0]   seq_q;
  logic [31:0]   done_q;
  logic [63:0]   addr_q;
  logic [127:0]  data_q;
  logic [63:0]   slot_off;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign empty     = (level == '0);
  assign push      = complete_push_i & ready_q;
  assign pop       = (state_q == IDLE) & ~empty & cmpl_enable_i;
  assign ack       = (state_q == REQ) & wr_ack_i;
  assign level_nxt = level + PW'(push) - PW'(pop);
  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign slot_off  = 64'(head[40:32]) << SLOT_SHIFT;

  // Ready is registered so the scheduler can gate its push with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ready_q <= (level_nxt != PW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= return_data_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop) state_d = REQ;
      REQ:  if (wr_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        addr_q <= cmpl_base_addr_i + slot_off;
        data_q <= {1'b1, 31'b0, seq_q, 23'b0, head};
      end
      if (ack) begin
        seq_q  <= seq_q + 1'b1;
        done_q <= done_q + 1'b1;
      end
    end
  end

  assign complete_ready_o = ready_q;
  assign wr_req_o         = (state_q == REQ);
  assign wr_addr_o        = addr_q;
  assign wr_data_o        = data_q;
  assign done_cnt_o       = done_q;
  assign fifo_level_o     = level;

endmodule

// File: tb/tb_completion_writer.sv
// Bench for completion_writer: queue-based reference model, directed
// cases and a randomized phase, all compared cycle by cycle.
module tb_completion_writer;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         complete_push_i = 1'b0;
  logic [40:0]  return_data_i = '0;
  logic         complete_ready_o;
  logic         cmpl_enable_i = 1'b0;
  logic [63:0]  cmpl_base_addr_i = '0;
  logic         wr_req_o;
  logic [63:0]  wr_addr_o;
  logic [127:0] wr_data_o;
  logic         wr_ack_i = 1'b0;
  logic [31:0]  done_cnt_o;
  logic [4:0]   fifo_level_o;

  int n_chk = 0;
  int n_err = 0;

  completion_writer #(.FIFO_DEPTH(DEPTH), .SLOT_SHIFT(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .complete_push_i(complete_push_i),
    .return_data_i(return_data_i),
    .complete_ready_o(complete_ready_o),
    .cmpl_enable_i(cmpl_enable_i),
    .cmpl_base_addr_i(cmpl_base_addr_i),
    .wr_req_o(wr_req_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .wr_ack_i(wr_ack_i),
    .done_cnt_o(done_cnt_o),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pending records in a queue, one record in flight.
  logic [40:0]  mq[$];
  bit           m_busy;
  logic [63:0]  m_addr;
  logic [127:0] m_data;
  logic [31:0]  m_seq;
  logic [31:0]  m_done;
  bit           m_ready;

  function automatic logic [127:0] fmt(logic [40:0] r, logic [31:0] s);
    logic [127:0] d;
    d = '0;
    d[31:0]  = r[31:0];
    d[40:32] = r[40:32];
    d[95:64] = s;
    d[127]   = 1'b1;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy  = 0;
      m_addr  = '0;
      m_data  = '0;
      m_seq   = '0;
      m_done  = '0;
      m_ready = 0;
    end else begin
      logic [40:0] r;
      bit can_pop;
      bit pok;
      if (complete_push_i) chk("push_ok", 128'(m_ready), 128'd1);
      pok = complete_push_i && m_ready;
      can_pop = !m_busy && mq.size() > 0 && cmpl_enable_i;
      if (m_busy && wr_ack_i) begin
        m_busy = 0;
        m_seq  = m_seq + 1;
        m_done = m_done + 1;
      end else if (can_pop) begin
        r = mq.pop_front();
        m_addr = cmpl_base_addr_i + ({55'b0, r[40:32]} * 64'd64);
        m_data = fmt(r, m_seq);
        m_busy = 1;
      end
      if (pok) mq.push_back(return_data_i);
      m_ready = (mq.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req", 128'(wr_req_o), 128'(m_busy));
      chk("ready", 128'(complete_ready_o), 128'(m_ready));
      chk("level", 128'(fifo_level_o), 128'(mq.size()));
      chk("done", 128'(done_cnt_o), 128'(m_done));
      if (m_busy) begin
        chk("addr", 128'(wr_addr_o), 128'(m_addr));
        chk("data", wr_data_o, m_data);
      end
    end
  end

  task automatic cyc(input bit want, input logic [8:0] pid,
                     input logic [31:0] job, input bit en, input bit ack);
    @(negedge clk);
    complete_push_i = want && complete_ready_o;
    return_data_i   = {pid, job};
    cmpl_enable_i   = en;
    wr_ack_i        = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    complete_push_i = 1'b0;
    wr_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_req", 128'(wr_req_o), 128'd0);
    chk("rst_ready", 128'(complete_ready_o), 128'd0);
    chk("rst_addr", 128'(wr_addr_o), 128'd0);
    chk("rst_data", wr_data_o, 128'd0);
    chk("rst_done", 128'(done_cnt_o), 128'd0);
    chk("rst_level", 128'(fifo_level_o), 128'd0);
    do_reset();
    #1 chk("ready_pre_edge", 128'(complete_ready_o), 128'd0);
    @(negedge clk);
    chk("ready_post_edge", 128'(complete_ready_o), 128'd1);

    // single record, latency and address
    cmpl_base_addr_i = 64'h1000_0000;
    cyc(1, 9'h005, 32'hDEAD_BEEF, 1, 0);
    chk("t1_req0", 128'(wr_req_o), 128'd0);
    cyc(0, 0, 0, 1, 0);
    chk("t1_req1", 128'(wr_req_o), 128'd0);
    cyc(0, 0, 0, 1, 1);
    chk("t1_req2", 128'(wr_req_o), 128'd1);
    chk("t1_addr", 128'(wr_addr_o), 128'h1000_0140);
    chk("t1_vld", 128'(wr_data_o[127]), 128'd1);
    chk("t1_seq", 128'(wr_data_o[95:64]), 128'd0);
    cyc(0, 0, 0, 1, 0);
    chk("t1_done", 128'(done_cnt_o), 128'd1);
    chk("t1_req_off", 128'(wr_req_o), 128'd0);

    // fill: one in REQ plus a full FIFO
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1, 9'(i), 32'h100 + i, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t2_level", 128'(fifo_level_o), 128'd16);
    chk("t2_ready", 128'(complete_ready_o), 128'd0);
    chk("t2_req", 128'(wr_req_o), 128'd1);
    cyc(1, 9'h1AA, 32'h5555, 1, 0);
    repeat (40) cyc(0, 0, 0, 1, 1);
    chk("t2_done", 128'(done_cnt_o), 128'd17);

    // disabled drain
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1, 9'(3 * i), 32'hA0 + i, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1);
    chk("t3_req", 128'(wr_req_o), 128'd0);
    chk("t3_level", 128'(fifo_level_o), 128'd3);
    repeat (10) cyc(0, 0, 0, 1, 1);
    chk("t3_done", 128'(done_cnt_o), 128'd3);

    // push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1, 9'(i + 7), 32'hB0 + i, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_level_a", 128'(fifo_level_o), 128'd4);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 9'h0EE, 32'hC0DE, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_level_b", 128'(fifo_level_o), 128'd4);
    repeat (20) cyc(0, 0, 0, 1, 1);
    chk("t4_done", 128'(done_cnt_o), 128'd6);

    // reset while a request is outstanding
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1, 9'(i), 32'hD0 + i, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t5_level", 128'(fifo_level_o), 128'd5);
    chk("t5_req", 128'(wr_req_o), 128'd1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_req", 128'(wr_req_o), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_level0", 128'(fifo_level_o), 128'd0);
    chk("t5_done0", 128'(done_cnt_o), 128'd0);
    chk("t5_ready", 128'(complete_ready_o), 128'd1);

    // address wrap and sequence wrap
    do_reset();
    cmpl_base_addr_i = 64'hFFFF_FFFF_FFFF_FFC0;
    @(negedge clk);
    force dut.seq_q = 32'hFFFF_FFFF;
    m_seq = 32'hFFFF_FFFF;
    #1 release dut.seq_q;
    cyc(1, 9'h1FF, 32'h1111_2222, 1, 0);
    cyc(1, 9'h1FF, 32'h3333_4444, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("t6_addr", 128'(wr_addr_o), 128'h7F80);
    chk("t6_seq_max", 128'(wr_data_o[95:64]), 128'hFFFF_FFFF);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("t6_seq_wrap", 128'(wr_data_o[95:64]), 128'd0);
    repeat (4) cyc(0, 0, 0, 1, 1);

    // randomized traffic
    do_reset();
    cmpl_base_addr_i = {$urandom, $urandom};
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom % 2), 9'($urandom), $urandom,
          ($urandom % 10) != 0, 1'($urandom % 2));
    repeat (60) cyc(0, 0, 0, 1, 1);
    chk("rand_empty", 128'(fifo_level_o), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
